fet_pfq: RTL
============

// Module: fet_pfq
// PURPOSE
//  Parametrised fetch stage with an instruction prefetch queue. Owns the PC, issues
//  reads to a registered (1-cycle) instruction memory and buffers returned words with
//  their PC/next-PC in a DEPTH-entry FIFO. Decode drains the FIFO via valid/ready.
//  Branch/jump resolution arrives as a single redirect that squashes queue and in-flight read.
// PARAMETERS
//  RESET_ADDR  32'h00000000  PC after reset; bits [1:0] must be 0
//  DEPTH       4             queue entries; power of 2, >= 2
// PORTS
//  i_clk          in   1   clock, all state on posedge
//  i_rst_n        in   1   asynchronous, active-low reset
//  i_redirect     in   1   resolved branch/jump taken; load i_redirect_pc, flush
//  i_redirect_pc  in   32  redirect target; bits [1:0] ignored (forced 0)
//  i_halt         in   1   stop issuing new fetches (level)
//  o_imem_ren     out  1   imem read issued this cycle
//  o_imem_raddr   out  32  imem read address (= current PC)
//  i_imem_rdata   in   32  read data, valid the cycle after o_imem_ren
//  o_vld          out  1   queue head valid
//  i_rdy          in   1   decode accepts head (pop when o_vld & i_rdy)
//  o_inst         out  32  head instruction
//  o_pc           out  32  head PC
//  o_nxt_pc       out  32  head PC + 4
//  o_flush        out  1   = i_redirect; downstream squash
//  o_count        out  $clog2(DEPTH)+1  current queue occupancy
// BEHAVIOUR
//  - Reset (async assert, sync release): pc_ff=RESET_ADDR, queue empty, inflight_ff=0;
//    o_vld=0, o_imem_ren=0, o_count=0, o_imem_raddr=RESET_ADDR; o_inst/o_pc/o_nxt_pc=0.
//  - pop = o_vld & i_rdy & ~i_redirect. push = inflight_ff & ~i_redirect.
//  - Issue: o_imem_ren = ~i_halt & ~i_redirect & (o_count + inflight_ff - pop < DEPTH).
//    Credit covers in-flight word, so a push never meets a full queue; no overflow path.
//  - On issue: pc_ff <= pc_ff + 4 (mod 2^32, 0xFFFFFFFC wraps to 0); inflight_ff <= 1,
//    inflight_pc_ff <= pc_ff. Without issue: inflight_ff <= 0.
//  - Push writes {i_imem_rdata, inflight_pc_ff, inflight_pc_ff+4} at tail.
//  - Latency: issue in cycle N -> data in N+1 -> o_vld/head in N+2. Steady state with
//    i_rdy=1: one instruction per cycle for any DEPTH >= 2.
//  - Head outputs come from queue storage at rd pointer; stable while o_vld & ~i_rdy.
//  - Simultaneous push+pop: occupancy unchanged, both pointers advance (wrap mod DEPTH).
//  - Redirect (highest priority): same cycle o_imem_ren=0, pop/push suppressed; next edge
//    pc_ff <= {i_redirect_pc[31:2],2'b00}, queue emptied, inflight_ff <= 0 (returning
//    word discarded). First fetch of target issued the cycle after redirect.
//  - Halt: no new issue; in-flight word still pushed; queue drains normally. Redirect
//    during halt still updates PC and flushes.
//  - Empty: o_vld=0, i_rdy ignored. Full: o_imem_ren=0 unless a pop frees space.
//  - Reset mid-operation: all state returns to reset values immediately; returning imem
//    data after reset release is ignored (inflight_ff=0).
// TESTING
//  1 Release reset, i_rdy=1 -> raddr 0x0,0x4,0x8... each cycle; o_vld first high 2
//    cycles after first ren with o_pc=0, o_nxt_pc=4.
//  2 DEPTH=4, i_rdy=0 -> exactly 4 pushes, o_count=4, ren low, pc_ff=0x10; then i_rdy=1
//    -> heads PC 0,4,8,C in order, ren resumes without gap or overflow.
//  3 Redirect to 0x103 while 3 queued + 1 in flight -> o_flush pulse, next cycle
//    o_vld=0, o_count=0, following ren with raddr 0x100; stale word never appears.
//  4 i_halt=1 with one read in flight -> that word queued, no further ren; halt release
//    -> fetch resumes at next sequential PC.
//  5 RESET_ADDR=0xFFFFFFF8 -> raddrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0; head o_nxt_pc of
//    0xFFFFFFFC equals 0x0.
//  6 Assert i_rst_n=0 mid-stream (queue 2 deep) -> o_vld, o_imem_ren, o_count drop to 0
//    asynchronously; after release fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/fet_pfq.sv
// Fetch stage with a DEPTH-entry instruction prefetch queue in front of a 1-cycle
// registered instruction memory; a redirect squashes the queue and any in-flight read.
module fet_pfq #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_redirect,
    input  logic [31:0]              i_redirect_pc,
    input  logic                     i_halt,
    output logic                     o_imem_ren,
    output logic [31:0]              o_imem_raddr,
    input  logic [31:0]              i_imem_rdata,
    output logic                     o_vld,
    input  logic                     i_rdy,
    output logic [31:0]              o_inst,
    output logic [31:0]              o_pc,
    output logic [31:0]              o_nxt_pc,
    output logic                     o_flush,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          run_q;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   nxt_mem_q  [DEPTH];

    logic          pop, push, issue;
    logic [SW-1:0] credit;

    assign pop    = o_vld & i_rdy & ~i_redirect;
    assign push   = inflight_q & ~i_redirect;
    // Occupancy plus the word already in flight, so an accepted issue always has a slot.
    assign credit = SW'(count_q) + SW'(inflight_q) - SW'(pop);
    // run_q keeps the read port quiet during the first cycle out of reset.
    assign issue  = run_q & ~i_halt & ~i_redirect & (credit < SW'(DEPTH));

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (i_redirect) begin
            pc_d     = {i_redirect_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q          <= RESET_ADDR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            run_q         <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            run_q         <= 1'b1;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // NOTE: the storage is reset on purpose so head outputs read zero out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
                nxt_mem_q[i]  <= '0;
            end
        end else if (push) begin
            inst_mem_q[wr_ptr_q] <= i_imem_rdata;
            pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
            nxt_mem_q[wr_ptr_q]  <= inflight_pc_q + 32'd4;
        end
    end

    assign o_imem_ren   = issue;
    assign o_imem_raddr = pc_q;
    assign o_vld        = (count_q != '0);
    assign o_inst       = inst_mem_q[rd_ptr_q];
    assign o_pc         = pc_mem_q[rd_ptr_q];
    assign o_nxt_pc     = nxt_mem_q[rd_ptr_q];
    assign o_flush      = i_redirect;
    assign o_count      = count_q;

endmodule
